// File: rtl/mult_div_unit.sv
// mult_div_unit: 32-cycle iterative MULT/MULTU/DIV/DIVU producing HI/LO.
// Signed ops run on magnitudes; the sign fixup is folded into the RUN-to-DONE register write.
module mult_div_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        has_div_w,
    output logic [31:0] reg_hi_w,
    output logic [31:0] reg_lo_w
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [1:0] op_q;
    logic [31:0] a_q, b_q, ma, mb, ia, ib, q_m, r_m;
    logic [64:0] acc, acc_nx;
    logic [32:0] sum, shl, diff;
    logic [63:0] prod, res;
    logic [5:0] cnt;
    logic sgn, neg_q, neg_r;
    always_comb begin
        ia = (~op[0] & operand_a[31]) ? -operand_a : operand_a;
        ib = (~op[0] & operand_b[31]) ? -operand_b : operand_b;
        sgn = ~op_q[0];
        ma = (sgn & a_q[31]) ? -a_q : a_q;
        mb = (sgn & b_q[31]) ? -b_q : b_q;
        neg_q = sgn & (a_q[31] ^ b_q[31]);
        neg_r = sgn & a_q[31];
        // multiply: upper 33 bits accumulate, lower 32 bits hold the shifting multiplier
        sum = acc[64:32] + (acc[0] ? {1'b0, ma} : 33'd0);
        // divide: upper 33 bits are the partial remainder, lower 32 bits shift dividend out / quotient in
        shl = {acc[63:32], acc[31]};
        diff = shl - {1'b0, mb};
        acc_nx = op_q[1] ? (diff[32] ? {shl, acc[30:0], 1'b0} : {diff, acc[30:0], 1'b1})
                         : {1'b0, sum, acc[31:1]};
        prod = acc_nx[63:0];
        q_m = acc_nx[31:0];
        r_m = acc_nx[63:32];
        res = !op_q[1] ? (neg_q ? -prod : prod) :
              (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} :
              {neg_r ? -r_m : r_m, neg_q ? -q_m : q_m};
        state_nx = state == RUN ? (cnt == 6'd31 ? DONE : RUN) : (start ? RUN : IDLE);
        busy = state == RUN;
        has_div_w = state == DONE;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            op_q <= 2'd0;
            a_q <= 32'd0;
            b_q <= 32'd0;
            acc <= 65'd0;
            cnt <= 6'd0;
            reg_hi_w <= 32'd0;
            reg_lo_w <= 32'd0;
        end else begin
            state <= state_nx;
            if (state != RUN && start) begin
                op_q <= op;
                a_q <= operand_a;
                b_q <= operand_b;
                acc <= {33'd0, op[1] ? ia : ib};
                cnt <= 6'd0;
            end else if (state == RUN) begin
                acc <= acc_nx;
                cnt <= cnt + 6'd1;
                if (cnt == 6'd31) begin
                    reg_hi_w <= res[63:32];
                    reg_lo_w <= res[31:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed + random scoreboard bench for mult_div_unit.
module tb_mult_div_unit;
    logic clock = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [1:0] op = 2'd0;
    logic [31:0] operand_a = 32'd0, operand_b = 32'd0;
    logic busy, has_div_w;
    logic [31:0] reg_hi_w, reg_lo_w;
    logic [63:0] sb[$];
    int checks = 0, passes = 0, fails = 0, pulses = 0;

    mult_div_unit dut (
        .clock(clock), .reset_n(reset_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .busy(busy),
        .has_div_w(has_div_w), .reg_hi_w(reg_hi_w), .reg_lo_w(reg_lo_w)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbv;
        sa = $signed({{32{a[31]}}, a});
        sbv = $signed({{32{b[31]}}, b});
        if (o == 2'd1) return {32'd0, a} * {32'd0, b};
        if (o == 2'd0) return sa * sbv;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'd3) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sbv), 32'(sa / sbv)};
    endfunction

    always @(negedge clock) begin
        if (reset_n && has_div_w) begin
            pulses++;
            if (sb.size() == 0) check("spurious_pulse", 64'd1, 64'd0);
            else check("result", {reg_hi_w, reg_lo_w}, sb.pop_front());
        end
    end

    task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        start = 1'b1;
        op = o;
        operand_a = a;
        operand_b = b;
        sb.push_back(exp);
    endtask

    task automatic track(input int inj);
        for (int n = 1; n <= 33; n++) begin
            @(negedge clock);
            if (n == 1) start = 1'b0;
            check($sformatf("busy_c%0d", n), {63'd0, busy}, {63'd0, n <= 32});
            check($sformatf("pulse_c%0d", n), {63'd0, has_div_w}, {63'd0, n == 33});
            if (n == inj) begin
                start = 1'b1;
                op = 2'd1;
                operand_a = 32'd9;
                operand_b = 32'd9;
            end
            if (n == inj + 1) start = 1'b0;
        end
    endtask

    task automatic gap();
        @(negedge clock);
    endtask

    initial begin
        logic [1:0] ro;
        logic [31:0] ra, rb;
        #2;
        check("rst_outs", {30'd0, busy, has_div_w, reg_hi_w | reg_lo_w}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        track(0);
        gap();
        drive(2'd0, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        track(0);
        gap();
        check("hold", {reg_hi_w, reg_lo_w}, 64'hFFFF_FFFF_FFFF_FFF1);
        drive(2'd3, 32'd100, 32'd7, {32'd2, 32'd14});
        track(0);
        gap();
        drive(2'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        track(0);
        gap();
        drive(2'd3, 32'd1234, 32'd0, {32'd1234, 32'hFFFF_FFFF});
        track(0);
        gap();
        drive(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
        track(0);
        gap();
        drive(2'd2, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        track(0);
        gap();
        drive(2'd1, 32'd6, 32'd7, 64'd42);
        track(10);
        drive(2'd1, 32'd9, 32'd9, 64'd81);
        track(0);
        gap();
        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : $urandom >> (i * 5);
            drive(ro, ra, rb, model(ro, ra, rb));
            track(0);
        end
        gap();
        drive(2'd1, 32'd6, 32'd7, 64'd42);
        for (int n = 1; n <= 15; n++) begin
            @(negedge clock);
            if (n == 1) start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("abort_outs", {30'd0, busy, has_div_w, reg_hi_w | reg_lo_w}, 64'd0);
        sb.delete();
        pulses = 0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int n = 0; n < 40; n++) @(negedge clock);
        check("abort_no_pulse", 64'(pulses), 64'd0);
        drive(2'd3, 32'd81, 32'd9, {32'd0, 32'd9});
        track(0);
        gap();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
